// File: rtl/alu_exec_unit.sv
//------------------------------------------------------------------------------
// Module   : alu_exec_unit
// Brief    : Registered ALU execute stage, valid/ready handshakes, iterative MUL.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_exec_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   alu_sel,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         carry,
  output logic         overflow,
  output logic         illegal
);

  localparam int CW = $clog2(N);

  localparam logic [3:0]    c_sel_and = 4'd0;
  localparam logic [3:0]    c_sel_or  = 4'd1;
  localparam logic [3:0]    c_sel_add = 4'd2;
  localparam logic [3:0]    c_sel_sub = 4'd6;
  localparam logic [3:0]    c_sel_slt = 4'd7;
  localparam logic [3:0]    c_sel_mul = 4'd8;
  localparam logic [CW-1:0] c_mul_last = CW'(N - 1);
  localparam logic [CW-1:0] c_cnt_one  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [N-1:0]  r_result;
  logic          r_zero;
  logic          r_carry;
  logic          r_overflow;
  logic          r_illegal;

  logic [N-1:0]  r_mcand;
  logic [N-1:0]  r_mplier;
  logic [N-1:0]  r_acc;
  logic [CW-1:0] r_cnt;

  logic          w_is_sub;
  logic [N-1:0]  w_b_eff;
  logic [N:0]    w_sum;
  logic          w_slt;
  logic [N-1:0]  w_res;
  logic          w_carry;
  logic          w_ovf;
  logic          w_ill;
  logic [N-1:0]  w_acc_next;
  logic          w_mul_last;

  // SUB shares the adder as a + ~b + 1 so carry is the no-borrow bit
  assign w_is_sub = (alu_sel == c_sel_sub);
  assign w_b_eff  = w_is_sub ? ~b : b;
  assign w_sum    = {1'b0, a} + {1'b0, w_b_eff} + {{N{1'b0}}, w_is_sub};
  assign w_slt    = ($signed(a) < $signed(b));

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_ill   = 1'b0;
    case (alu_sel)
      c_sel_and: w_res = a & b;
      c_sel_or:  w_res = a | b;
      c_sel_add: begin
        w_res   = w_sum[N-1:0];
        w_carry = w_sum[N];
        w_ovf   = (a[N-1] == b[N-1]) && (w_sum[N-1] != a[N-1]);
      end
      c_sel_sub: begin
        w_res   = w_sum[N-1:0];
        w_carry = w_sum[N];
        w_ovf   = (a[N-1] != b[N-1]) && (w_sum[N-1] != a[N-1]);
      end
      c_sel_slt: w_res = {{(N-1){1'b0}}, w_slt};
      c_sel_mul: w_res = '0;
      default:   w_ill = 1'b1;
    endcase
  end

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mul_last = (r_cnt == c_mul_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_next = (alu_sel == c_sel_mul) ? S_MUL : S_DONE;
        end
      end
      S_MUL: begin
        if (w_mul_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (alu_sel == c_sel_mul) begin
              r_mcand  <= a;
              r_mplier <= b;
              r_acc    <= '0;
              r_cnt    <= '0;
            end else begin
              r_result   <= w_res;
              r_zero     <= (w_res == '0);
              r_carry    <= w_carry;
              r_overflow <= w_ovf;
              r_illegal  <= w_ill;
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= {r_mcand[N-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[N-1:1]};
          r_cnt    <= r_cnt + c_cnt_one;
          // Final iteration writes the product straight into the output register
          if (w_mul_last) begin
            r_result   <= w_acc_next;
            r_zero     <= (w_acc_next == '0);
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_exec_unit
// Brief    : Directed and randomized bench for alu_exec_unit with a reference model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_exec_unit;

  localparam int N = 32;
  localparam longint c_max_s = 64'sd2147483647;
  localparam longint c_min_s = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   alu_sel = 4'd0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] result;
  logic         zero;
  logic         carry;
  logic         overflow;
  logic         illegal;

  int errors = 0;
  int checks = 0;

  alu_exec_unit #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_sel(alu_sel), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .carry(carry),
    .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic on wide integers, independent of how the unit computes it
  function automatic void ref_op(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic z, output logic c,
                                 output logic o, output logic il);
    longint      sx;
    longint      sy;
    longint      t;
    logic [32:0] w;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0; c = 1'b0; o = 1'b0; il = 1'b0;
    case (s)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd2: begin
        w = {1'b0, x} + {1'b0, y};
        r = w[31:0];
        c = w[32];
        t = sx + sy;
        o = (t > c_max_s) || (t < c_min_s);
      end
      4'd6: begin
        r = x - y;
        c = (x >= y);
        t = sx - sy;
        o = (t > c_max_s) || (t < c_min_s);
      end
      4'd7: r = (sx < sy) ? 32'd1 : 32'd0;
      4'd8: begin
        p = 64'(x) * 64'(y);
        r = p[31:0];
      end
      default: il = 1'b1;
    endcase
    z = (r == '0);
  endfunction

  // Transaction-level model: idle/busy, remaining latency, expected output fields
  logic         m_started = 1'b0;
  logic         m_idle = 1'b1;
  logic         m_valid = 1'b0;
  int           m_wait = 0;
  logic [31:0]  e_res = '0, p_res = '0;
  logic         e_z = 1'b0, e_c = 1'b0, e_o = 1'b0, e_i = 1'b0;
  logic         p_z = 1'b0, p_c = 1'b0, p_o = 1'b0, p_i = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_started = 1'b1;
      m_idle = 1'b1; m_valid = 1'b0; m_wait = 0;
      e_res = '0; e_z = 1'b0; e_c = 1'b0; e_o = 1'b0; e_i = 1'b0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 1'b0;
        m_idle = 1'b1;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1'b1;
        e_res = p_res; e_z = p_z; e_c = p_c; e_o = p_o; e_i = p_i;
      end
    end else if (m_idle && in_valid) begin
      ref_op(alu_sel, a, b, p_res, p_z, p_c, p_o, p_i);
      m_idle = 1'b0;
      if (alu_sel == 4'd8) begin
        m_wait = N;
      end else begin
        m_valid = 1'b1;
        e_res = p_res; e_z = p_z; e_c = p_c; e_o = p_o; e_i = p_i;
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("in_ready", 64'(in_ready), 64'(m_idle));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("result", 64'(result), 64'(e_res));
      chk("zero", 64'(zero), 64'(e_z));
      chk("carry", 64'(carry), 64'(e_c));
      chk("overflow", 64'(overflow), 64'(e_o));
      chk("illegal", 64'(illegal), 64'(e_i));
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("idle_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input string nm, input logic [3:0] s, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] er, input logic ez,
                        input logic ec, input logic eo, input logic ei, input int elat);
    int   lat;
    logic seen;
    wait_idle();
    in_valid = 1'b1; alu_sel = s; a = x; b = y; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; alu_sel = 4'($urandom);
    lat = 1; seen = 1'b0;
    while (!seen && lat < 100) begin
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    chk({nm, "_lat"}, 64'(lat), 64'(elat));
    chk({nm, "_res"}, 64'(result), 64'(er));
    chk({nm, "_flags"}, {60'd0, zero, carry, overflow, illegal}, {60'd0, ez, ec, eo, ei});
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] pick_sel();
    case ($urandom_range(0, 7))
      0:       return 4'd0;
      1:       return 4'd1;
      2:       return 4'd2;
      3:       return 4'd6;
      4:       return 4'd7;
      5:       return 4'd8;
      6:       return 4'($urandom_range(0, 15));
      default: return 4'd2;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);

    run_op("add_5_7", 4'd2, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run_op("sub_3_3", 4'd6, 32'd3, 32'd3, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    run_op("sub_ovf", 4'd6, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    run_op("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    run_op("mul_1234", 4'd8, 32'h1234, 32'h10, 32'h12340, 1'b0, 1'b0, 1'b0, 1'b0, 33);
    run_op("mul_ff", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 33);
    run_op("slt_neg", 4'd7, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run_op("or_ff", 4'd1, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run_op("illegal5", 4'd5, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1);

    // Backpressure: result must hold while a competing request is presented
    wait_idle();
    in_valid = 1'b1; alu_sel = 4'd2; a = 32'd1; b = 32'd1; out_ready = 1'b0;
    @(posedge clk); #1;
    alu_sel = 4'd6; a = 32'd9; b = 32'd3;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_result", 64'(result), 64'd2);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_drop", 64'(out_valid), 64'd0);
    chk("bp_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of a multiply
    wait_idle();
    in_valid = 1'b1; alu_sel = 4'd8; a = 32'd77; b = 32'd99;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("mulrst_nov", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mulrst_valid", 64'(out_valid), 64'd0);
    chk("mulrst_result", 64'(result), 64'd0);
    chk("mulrst_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 40; i++) begin
      if (out_valid) chk("mulrst_late", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    run_op("add_2_2", 4'd2, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    // Randomized traffic, checked each cycle against the model
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      alu_sel   = pick_sel();
      a         = pick_operand();
      b         = pick_operand();
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
